stall_ctrl: RTL and testbench
=============================

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5: busy cycles for a multiply started in E.
REQ-002 Parameter DIV_CYC, default 10: busy cycles for a divide started in E.
REQ-003 clk  in  1: single clock; all state updates on the rising edge.
REQ-004 res  in  1: reset, asynchronous, active-low.
REQ-005 D_rs, D_rt  in  5 each: source register numbers of the instruction in D.
REQ-006 D_Tuse_rs, D_Tuse_rt  in  2 each: cycles until D needs rs/rt (3 = not used).
REQ-007 E_A3, M_A3  in  5 each: destination register of the instruction in E and in M (0 = none).
REQ-008 E_Tnew, M_Tnew  in  2 each: cycles until the E/M result is forwardable, valid as presented at that stage.
REQ-009 D_is_md  in  1: D holds mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 E_md_start  in  1: E holds mult/multu/div/divu this cycle.
REQ-011 E_md_div  in  1: qualifies E_md_start; 1 = divide, 0 = multiply.
REQ-012 PC_WE  out  1: PC register write enable.
REQ-013 D_WE  out  1: F->D pipeline register write enable.
REQ-014 E_clr  out  1: synchronous clear of the D->E register (bubble insert).
REQ-015 md_busy  out  1: multiply/divide unit busy.
REQ-016 stall_cnt  out  32: count of stalled cycles since reset.

Function
REQ-017 rs hazard SHALL be D_rs!=0 and ((D_rs==E_A3 and D_Tuse_rs<E_Tnew) or (D_rs==M_A3 and D_Tuse_rs<M_Tnew)).
REQ-018 rt hazard SHALL be defined identically using D_rt and D_Tuse_rt.
REQ-019 md_busy SHALL be (state==BUSY) or E_md_start; md_stall SHALL be D_is_md and md_busy.
REQ-020 stall SHALL be rs hazard or rt hazard or md_stall; it is purely combinational with zero latency.
REQ-021 PC_WE=D_WE=not stall; E_clr=stall; the same cycle, no registering.
REQ-022 The FSM SHALL have two states: IDLE and BUSY; counter md_cnt is 4 bits wide and must hold max(MULT_CYC,DIV_CYC).
REQ-023 In IDLE with E_md_start=1: md_cnt<=DIV_CYC if E_md_div else MULT_CYC, next state BUSY.
REQ-024 In BUSY: md_cnt decrements by 1 per cycle; when md_cnt==1 the next state SHALL be IDLE and md_cnt<=0.
REQ-025 The total busy window SHALL be N+1 cycles (start cycle plus N BUSY cycles), N = MULT_CYC or DIV_CYC.
REQ-026 E_md_start while BUSY SHALL be ignored: state and md_cnt are unchanged.
REQ-027 Simultaneous data hazard and md_stall produce a single stall cycle; the two causes do not accumulate.
REQ-028 stall_cnt SHALL increment by 1 on each rising edge where stall=1 and saturate at 0xFFFFFFFF without wrapping.
REQ-029 A register number of 0 never causes a hazard, even when E_A3 or M_A3 is 0.

Reset
REQ-030 When res=0, regardless of clk: state=IDLE, md_cnt=0, stall_cnt=0.
REQ-031 While res=0, PC_WE=1, D_WE=1, E_clr=0, and md_busy=0; all stall terms are masked.
REQ-032 Reset asserted mid-BUSY SHALL abort the operation immediately; the first edge after release starts from IDLE.

Verification
REQ-033 Load-use: E_A3=8, E_Tnew=2, D_rs=8, D_Tuse_rs=1 -> PC_WE=0, D_WE=0, E_clr=1 that cycle; stall_cnt 0->1.
REQ-034 Zero register: E_A3=0, E_Tnew=2, D_rs=0, D_Tuse_rs=0 -> no stall, PC_WE=1.
REQ-035 Multiply: E_md_start=1, E_md_div=0 at cycle t -> md_busy=1 for cycles t..t+5 and 0 at t+6; with D_is_md=1 held, D_WE=0 for those 6 cycles.
REQ-036 Divide plus reset: start divide, drop res at BUSY cycle 4 -> md_busy=0 immediately and stall_cnt=0; after release, D_is_md=1 gives no stall.
REQ-037 Saturation: force stall_cnt to 0xFFFFFFFE and stall 3 cycles -> the count reads 0xFFFFFFFF and holds.
REQ-038 Start while BUSY: assert a second E_md_start during BUSY of a multiply -> busy ends at t+6, unchanged.

Source files
------------

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stall_ctrl
//  Description : Pipeline interlock for a five-stage MIPS-style core.
//                Detects D-stage RAW hazards against E/M using Tuse/Tnew,
//                tracks the multi-cycle mult/div unit, and produces PC/D
//                write enables, the E-stage bubble, and a stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        res,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic [4:0]  E_A3,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [1:0]  M_Tnew,
    input  logic        D_is_md,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        PC_WE,
    output logic        D_WE,
    output logic        E_clr,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    // FSM encoding for the mult/div occupancy tracker
    localparam logic [0:0]  c_ST_IDLE   = 1'b0;
    localparam logic [0:0]  c_ST_BUSY   = 1'b1;

    // Busy-cycle reload values; the 4-bit counter holds up to 15
    localparam logic [3:0]  c_MULT_LOAD = MULT_CYC[3:0];
    localparam logic [3:0]  c_DIV_LOAD  = DIV_CYC[3:0];
    localparam logic [31:0] c_CNT_MAX   = 32'hFFFF_FFFF;

    logic [0:0]  r_state;
    logic [3:0]  r_md_cnt;
    logic [31:0] r_stall_cnt;

    logic w_rs_hit_e;
    logic w_rs_hit_m;
    logic w_rt_hit_e;
    logic w_rt_hit_m;
    logic w_rs_hazard;
    logic w_rt_hazard;
    logic w_md_busy;
    logic w_md_stall;
    logic w_stall;

    // A source hits a producer when the names match and the value is not
    // ready by the time D needs it (Tuse strictly less than Tnew).
    assign w_rs_hit_e  = (D_rs == E_A3) && (D_Tuse_rs < E_Tnew);
    assign w_rs_hit_m  = (D_rs == M_A3) && (D_Tuse_rs < M_Tnew);
    assign w_rt_hit_e  = (D_rt == E_A3) && (D_Tuse_rt < E_Tnew);
    assign w_rt_hit_m  = (D_rt == M_A3) && (D_Tuse_rt < M_Tnew);

    // $zero is never a real dependency, which also covers "no destination"
    // being encoded as register 0 in E_A3/M_A3.
    assign w_rs_hazard = (D_rs != 5'd0) && (w_rs_hit_e || w_rs_hit_m);
    assign w_rt_hazard = (D_rt != 5'd0) && (w_rt_hit_e || w_rt_hit_m);

    // The unit counts as busy in the start cycle itself, before the FSM
    // has registered the operation. Reset masks every stall source so the
    // pipeline free-runs while held in reset.
    assign w_md_busy   = res && ((r_state == c_ST_BUSY) || E_md_start);
    assign w_md_stall  = D_is_md && w_md_busy;

    // All causes are OR-ed into one stall: simultaneous causes cost one cycle
    assign w_stall     = res && (w_rs_hazard || w_rt_hazard || w_md_stall);

    assign PC_WE       = ~w_stall;
    assign D_WE        = ~w_stall;
    assign E_clr       = w_stall;
    assign md_busy     = w_md_busy;
    assign stall_cnt   = r_stall_cnt;

    // Mult/div occupancy FSM: load on start, count down, return to IDLE on 1
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state  <= c_ST_IDLE;
            r_md_cnt <= 4'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (E_md_start) begin
                        r_md_cnt <= E_md_div ? c_DIV_LOAD : c_MULT_LOAD;
                        r_state  <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    // A new start here is ignored; the running op owns the unit
                    if (r_md_cnt == 4'd1) begin
                        r_md_cnt <= 4'd0;
                        r_state  <= c_ST_IDLE;
                    end else begin
                        r_md_cnt <= r_md_cnt - 4'd1;
                    end
                end
                default: begin
                    r_md_cnt <= 4'd0;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles since reset
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stall_ctrl
//  Description : Directed self-checking bench for stall_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_ctrl;

    logic        clk;
    logic        res;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_Tuse_rs;
    logic [1:0]  D_Tuse_rt;
    logic [4:0]  E_A3;
    logic [4:0]  M_A3;
    logic [1:0]  E_Tnew;
    logic [1:0]  M_Tnew;
    logic        D_is_md;
    logic        E_md_start;
    logic        E_md_div;
    logic        PC_WE;
    logic        D_WE;
    logic        E_clr;
    logic        md_busy;
    logic [31:0] stall_cnt;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_cnt;

    stall_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10)
    ) dut (
        .clk        (clk),
        .res        (res),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_Tuse_rs  (D_Tuse_rs),
        .D_Tuse_rt  (D_Tuse_rt),
        .E_A3       (E_A3),
        .M_A3       (M_A3),
        .E_Tnew     (E_Tnew),
        .M_Tnew     (M_Tnew),
        .D_is_md    (D_is_md),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .PC_WE      (PC_WE),
        .D_WE       (D_WE),
        .E_clr      (E_clr),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        D_rs       = 5'd0;
        D_rt       = 5'd0;
        D_Tuse_rs  = 2'd3;
        D_Tuse_rt  = 2'd3;
        E_A3       = 5'd0;
        M_A3       = 5'd0;
        E_Tnew     = 2'd0;
        M_Tnew     = 2'd0;
        D_is_md    = 1'b0;
        E_md_start = 1'b0;
        E_md_div   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        res = 1'b0;
        // Drive a hazard and an md start while in reset: all must be masked
        E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd0;
        D_is_md = 1'b1; E_md_start = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (PC_WE !== 1'b1) begin n_errors++; $display("FAIL reset_pc_we got %b exp 1", PC_WE); end
        n_checks++; if (D_WE !== 1'b1) begin n_errors++; $display("FAIL reset_d_we got %b exp 1", D_WE); end
        n_checks++; if (E_clr !== 1'b0) begin n_errors++; $display("FAIL reset_e_clr got %b exp 0", E_clr); end
        n_checks++; if (md_busy !== 1'b0) begin n_errors++; $display("FAIL reset_md_busy got %b exp 0", md_busy); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_stall_cnt got %h exp 0", stall_cnt); end
        @(negedge clk);
        idle_inputs();
        res = 1'b1;
        exp_cnt = 32'd0;
        @(negedge clk);
        #1;
        n_checks++; if (md_busy !== 1'b0) begin n_errors++; $display("FAIL post_reset_md_busy got %b exp 0", md_busy); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd1;
        #1;
        n_checks++; if (PC_WE !== 1'b0) begin n_errors++; $display("FAIL load_use_pc_we got %b exp 0", PC_WE); end
        n_checks++; if (D_WE !== 1'b0) begin n_errors++; $display("FAIL load_use_d_we got %b exp 0", D_WE); end
        n_checks++; if (E_clr !== 1'b1) begin n_errors++; $display("FAIL load_use_e_clr got %b exp 1", E_clr); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_errors++; $display("FAIL load_use_cnt_before got %h exp 0", stall_cnt); end
        @(negedge clk);
        idle_inputs();
        exp_cnt = exp_cnt + 32'd1;
        #1;
        n_checks++; if (stall_cnt !== 32'd1) begin n_errors++; $display("FAIL load_use_cnt_after got %h exp 1", stall_cnt); end
        n_checks++; if (PC_WE !== 1'b1) begin n_errors++; $display("FAIL load_use_release got %b exp 1", PC_WE); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        E_A3 = 5'd0; E_Tnew = 2'd2; D_rs = 5'd0; D_Tuse_rs = 2'd0;
        M_A3 = 5'd0; M_Tnew = 2'd3; D_rt = 5'd0; D_Tuse_rt = 2'd0;
        #1;
        n_checks++; if (PC_WE !== 1'b1) begin n_errors++; $display("FAIL zero_reg_pc_we got %b exp 1", PC_WE); end
        n_checks++; if (E_clr !== 1'b0) begin n_errors++; $display("FAIL zero_reg_e_clr got %b exp 0", E_clr); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL zero_reg_cnt got %h exp %h", stall_cnt, exp_cnt); end
    endtask

    task automatic test_rt_mem_hazard();
        // rt against M: Tuse 0 < Tnew 1 stalls, Tuse 1 == Tnew 1 does not
        @(negedge clk);
        M_A3 = 5'd5; M_Tnew = 2'd1; D_rt = 5'd5; D_Tuse_rt = 2'd0;
        #1;
        n_checks++; if (D_WE !== 1'b0) begin n_errors++; $display("FAIL rt_m_stall got %b exp 0", D_WE); end
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        D_Tuse_rt = 2'd1;
        #1;
        n_checks++; if (D_WE !== 1'b1) begin n_errors++; $display("FAIL rt_m_equal_tuse got %b exp 1", D_WE); end
        // Different register in E with long Tnew must not match
        E_A3 = 5'd6; E_Tnew = 2'd3; D_Tuse_rt = 2'd3;
        #1;
        n_checks++; if (E_clr !== 1'b0) begin n_errors++; $display("FAIL rt_e_other_reg got %b exp 0", E_clr); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL rt_m_cnt got %h exp %h", stall_cnt, exp_cnt); end
    endtask

    task automatic test_multiply();
        // Start at cycle t with D_is_md held and a coincident load-use hazard
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                E_md_start = 1'b1; E_md_div = 1'b0; D_is_md = 1'b1;
                E_A3 = 5'd9; E_Tnew = 2'd2; D_rs = 5'd9; D_Tuse_rs = 2'd0;
            end else if (k == 1) begin
                E_md_start = 1'b0;
                E_A3 = 5'd0; E_Tnew = 2'd0; D_rs = 5'd0; D_Tuse_rs = 2'd3;
            end
            #1;
            n_checks++; if (md_busy !== (k <= 5)) begin n_errors++; $display("FAIL mult_busy k=%0d got %b exp %b", k, md_busy, (k <= 5)); end
            n_checks++; if (D_WE !== (k > 5)) begin n_errors++; $display("FAIL mult_d_we k=%0d got %b exp %b", k, D_WE, (k > 5)); end
        end
        exp_cnt = exp_cnt + 32'd6;
        n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL mult_cnt got %h exp %h", stall_cnt, exp_cnt); end
        idle_inputs();
    endtask

    task automatic test_start_while_busy();
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            E_md_start = (k == 0) || (k == 2);
            E_md_div   = (k == 2);
            #1;
            if (k >= 4) begin
                n_checks++; if (md_busy !== (k <= 5)) begin n_errors++; $display("FAIL restart_busy k=%0d got %b exp %b", k, md_busy, (k <= 5)); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_div_reset();
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                E_md_start = 1'b1; E_md_div = 1'b1; D_is_md = 1'b1;
            end else begin
                E_md_start = 1'b0;
            end
        end
        exp_cnt = exp_cnt + 32'd4;
        #1;
        n_checks++; if (md_busy !== 1'b1) begin n_errors++; $display("FAIL div_busy_pre got %b exp 1", md_busy); end
        n_checks++; if (stall_cnt !== exp_cnt) begin n_errors++; $display("FAIL div_cnt_pre got %h exp %h", stall_cnt, exp_cnt); end
        res = 1'b0;
        exp_cnt = 32'd0;
        #1;
        n_checks++; if (md_busy !== 1'b0) begin n_errors++; $display("FAIL div_rst_busy got %b exp 0", md_busy); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_errors++; $display("FAIL div_rst_cnt got %h exp 0", stall_cnt); end
        n_checks++; if (D_WE !== 1'b1) begin n_errors++; $display("FAIL div_rst_d_we got %b exp 1", D_WE); end
        @(negedge clk);
        res = 1'b1;
        #1;
        n_checks++; if (D_WE !== 1'b1) begin n_errors++; $display("FAIL div_release_d_we got %b exp 1", D_WE); end
        @(negedge clk);
        #1;
        n_checks++; if (md_busy !== 1'b0) begin n_errors++; $display("FAIL div_release_busy got %b exp 0", md_busy); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_errors++; $display("FAIL div_release_cnt got %h exp 0", stall_cnt); end
        idle_inputs();
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        E_A3 = 5'd3; E_Tnew = 2'd2; D_rs = 5'd3; D_Tuse_rs = 2'd1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            n_checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL sat_cnt k=%0d got %h exp ffffffff", k, stall_cnt); end
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 32'd0;
        res      = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_rt_mem_hazard();
        test_multiply();
        test_start_while_busy();
        test_div_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
